// File: rtl/rst_release_seq_pkg.sv
// rtl/rst_release_seq_pkg.sv - shared state encodings and helpers for the reset release sequencer
//
// Purpose: state encoding for the sequencer FSM and a width helper for the release index.
// Ports:   none (package).

package rst_release_seq_pkg;

    // Six legal encodings out of eight; the two spare codes fall back to ST_RST.
    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_HOLD    = 3'd1,
        ST_REL     = 3'd2,
        ST_DONE    = 3'd3,
        ST_SW_HOLD = 3'd4,
        ST_SW_WAIT = 3'd5
    } state_t;

    // Width needed to count 0..n inclusive (the index steps one past the last output).
    function automatic int idx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rst_release_seq_sync_nff.sv
// rtl/rst_release_seq_sync_nff.sv - N-flop reset release synchroniser with asynchronous clear
//
// Purpose: assert asynchronously with i_rstn, release synchronously after STAGES clock edges.
// Ports:
//   i_clk       in   1   clock
//   i_rstn      in   1   raw asynchronous active-low reset
//   o_srst_n    out  1   synchronised reset (last flop)
//   o_srst_pre  out  1   value that o_srst_n takes on the next edge (second-to-last flop)

module rst_sync_nff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    output logic o_srst_n,
    output logic o_srst_pre
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], 1'b1};
        end
    end

    assign o_srst_n   = r_sync[STAGES-1];
    // Exposed so the consumer can act on the very edge where o_srst_n rises.
    assign o_srst_pre = r_sync[STAGES-2];

endmodule

// File: rtl/rst_release_seq.sv
// rtl/rst_release_seq.sv - sequenced release of NUM_OUT downstream resets with sw reset handshake
//
// Purpose: synchronise the release of the board reset, hold all outputs for HOLD_CYC cycles,
//          then release rst_out_n[0..NUM_OUT-1] one every GAP_CYC cycles. From DONE a 4-phase
//          software request re-asserts all outputs and re-runs the release order.
// Ports:
//   clk         in   1        clock
//   rstn        in   1        asynchronous active-low reset
//   sw_rst_req  in   1        level software reset request, synchronous to clk
//   sw_rst_ack  out  1        handshake ack (registered)
//   rst_out_n   out  NUM_OUT  sequenced active-low resets, bit 0 released first (registered)
//   rst_done    out  1        all outputs released (registered)
//   busy        out  1        FSM not in DONE (registered)

module rst_release_seq
    import rst_release_seq_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 8,
    parameter int GAP_CYC     = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sw_rst_req,
    output logic               sw_rst_ack,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               rst_done,
    output logic               busy
);

    localparam int IDX_W = idx_width(NUM_OUT);

    // Parameter legality checks at elaboration.
    if (NUM_OUT < 1) begin : g_bad_num_out
        $error("NUM_OUT must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYC < 1 || GAP_CYC < 1) begin : g_bad_cyc
        $error("HOLD_CYC and GAP_CYC must be >= 1");
    end
    if (HOLD_CYC >= (1 << CNT_W) || GAP_CYC >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for HOLD_CYC/GAP_CYC");
    end

    logic w_srst_n;
    logic w_srst_pre;

    rst_sync_nff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .o_srst_n   (w_srst_n),
        .o_srst_pre (w_srst_pre)
    );

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_OUT-1:0] r_rst_out_n;
    logic               r_done;
    logic               r_busy;
    logic               r_ack;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [NUM_OUT-1:0] w_out_nxt;
    logic               w_done_nxt;
    logic               w_busy_nxt;
    logic               w_ack_nxt;

    // Counter expiry. "<= 1" rather than "== 1" so a counter found at 0 still moves on.
    logic w_tick;
    logic w_last;
    assign w_tick = (r_cnt <= CNT_W'(1));
    assign w_last = (r_idx == IDX_W'(NUM_OUT - 1));

    // State, counter, index and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_out_n <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rst_out_n <= w_out_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_ack       <= w_ack_nxt;
        end
    end

    // Next state, counter and release index.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : '0;
        w_idx_nxt   = r_idx;

        case (r_state)
            ST_RST: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                // Leave on the edge where the synchronised reset itself releases.
                if (w_srst_pre) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = CNT_W'(HOLD_CYC);
                end
            end
            ST_HOLD, ST_REL: begin
                if (w_tick) begin
                    w_cnt_nxt   = CNT_W'(GAP_CYC);
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = w_last ? ST_DONE : ST_REL;
                end
            end
            ST_DONE: begin
                w_cnt_nxt = '0;
                if (sw_rst_req) begin
                    w_state_nxt = ST_SW_HOLD;
                    w_cnt_nxt   = CNT_W'(HOLD_CYC);
                    w_idx_nxt   = '0;
                end
            end
            ST_SW_HOLD: begin
                if (w_tick) begin
                    if (sw_rst_req) begin
                        w_state_nxt = ST_SW_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        // Request dropped early: skip the ack and start releasing.
                        w_state_nxt = ST_REL;
                        w_cnt_nxt   = CNT_W'(GAP_CYC);
                        w_idx_nxt   = '0;
                    end
                end
            end
            ST_SW_WAIT: begin
                w_cnt_nxt = '0;
                if (!sw_rst_req) begin
                    w_state_nxt = ST_REL;
                    w_cnt_nxt   = CNT_W'(GAP_CYC);
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RST;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        // Outside ST_RST the synchronised reset is always high; if it is not, start over.
        if (!w_srst_n && r_state != ST_RST) begin
            w_state_nxt = ST_RST;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        w_out_nxt = r_rst_out_n;
        w_ack_nxt = 1'b0;

        case (r_state)
            ST_HOLD, ST_REL: begin
                if (w_tick) begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            w_out_nxt[i] = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (sw_rst_req) begin
                    w_out_nxt = '0;
                end
            end
            ST_SW_HOLD: begin
                w_out_nxt = '0;
                w_ack_nxt = w_tick && sw_rst_req;
            end
            ST_SW_WAIT: begin
                w_out_nxt = '0;
                // Ack follows req so it drops on the edge that samples req low.
                w_ack_nxt = sw_rst_req;
            end
            default: begin
                w_out_nxt = '0;
            end
        endcase

        if (w_state_nxt == ST_RST) begin
            w_out_nxt = '0;
            w_ack_nxt = 1'b0;
        end

        w_done_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt = (w_state_nxt != ST_DONE);
    end

    assign rst_out_n  = r_rst_out_n;
    assign rst_done   = r_done;
    assign busy       = r_busy;
    assign sw_rst_ack = r_ack;

endmodule
